// File: rtl/ula_pkg.sv
// ula_pkg: opcode and state types shared by the bit-serial ALU.
package ula_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } ula_op_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ula_state_t;

  function automatic logic is_sum(input logic [2:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_SLT;
  endfunction
endpackage

// File: rtl/ula_bit.sv
// ula_bit: one-bit ALU slice; reserved opcodes yield 0 so a full run produces an all-zero result.
module ula_bit
  import ula_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       s,
  output logic       cout
);
  assign s    = op == OP_AND ? a & b : op == OP_OR ? a | b : is_sum(op) ? a ^ b ^ cin : 1'b0;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ula_serial.sv
// ula_serial: bit-serial ALU, one bit per clock LSB first through a single slice,
// with valid/ready handshakes on both sides.
module ula_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ULAcontrole,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ULAsaida,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  ula_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [2:0]       r_op;
  logic             r_cy, r_zero, r_carry, r_ovf;
  logic             w_s, w_cout, w_last, w_flag, w_slt, w_ovf;
  logic [WIDTH-1:0] w_shift, w_res;
  ula_bit u_bit (
    .a   (r_a[0]),
    .b   (r_b[0] ^ r_op[2]),
    .cin (r_cy),
    .op  (r_op),
    .s   (w_s),
    .cout(w_cout)
  );
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  assign w_flag  = r_op == OP_ADD || r_op == OP_SUB;
  assign w_slt   = r_op == OP_SLT;
  assign w_ovf   = r_cy ^ w_cout;
  assign w_shift = {w_s, r_res[WIDTH-1:1]};
  // SLT replaces the shifted sum with the corrected sign bit once the MSB is known
  assign w_res   = w_slt ? {{(WIDTH - 1) {1'b0}}, w_s ^ w_ovf} : w_shift;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign ULAsaida  = r_res;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_cy    <= 1'b0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (in_valid) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_op    <= ULAcontrole;
            r_cy    <= ULAcontrole[2];
          end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cy  <= w_cout;
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          r_res <= w_last ? w_res : w_shift;
          if (w_last) begin
            r_state <= DONE;
            r_zero  <= w_res == '0;
            r_carry <= w_flag & w_cout;
            r_ovf   <= w_flag & w_ovf;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ula_serial.md
# ula_serial

Bit-serial multi-cycle ALU for the MIPS datapath. It accepts two WIDTH-bit operands and a 3-bit operation code over a valid/ready handshake. It processes one bit per clock, LSB first, through a single 1-bit ALU slice with a registered carry. It returns the WIDTH-bit result plus zero, carry and overflow flags over a second valid/ready handshake. It serves as the area-minimal execution unit, trading latency for a single slice of logic.

## Interface
- WIDTH, 32, operand and result width in bits, minimum 2
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands and opcode are valid
- in_ready  output  1  block is able to accept new operands
- ULAcontrole  input  3  operation code, sampled on input handshake
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- ULAsaida  output  WIDTH  result
- zero  output  1  result is all zeros
- carry  output  1  carry out of the MSB; ADD/SUB only
- overflow  output  1  signed overflow; ADD/SUB only

## Operation
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB, computed as A + ~B + 1
  - 111 SLT, signed A < B
  - 011/100/101 reserved: full WIDTH-cycle run, result 0, zero=1, carry=0, overflow=0
- Input handshake:
  - a, b and ULAcontrole are captured on the edge where in_valid && in_ready.
  - addsub = ULAcontrole[2].
  - The carry register is initialised to addsub: 1 for SUB/SLT, 0 otherwise.
- State machine:
  - IDLE: in_ready=1. Input handshake → RUN, bit counter = 0.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - The slice takes a_sh[0], b_sh[0] ^ addsub and the carry register.
    - The slice output is shifted into the MSB of the result shift register.
    - Operand shift registers shift right by one.
    - Carry register ← slice cout.
    - Counter increments. When counter == WIDTH-1 → DONE.
  - DONE: out_valid=1, outputs held stable. out_valid && out_ready → IDLE.
- Flags at the MSB cycle, ADD/SUB/SLT:
  - carry = slice cout.
  - overflow = carry-in to MSB ^ carry-out of MSB.
  - For SLT, ULAsaida = {WIDTH-1 zeros, sum_msb ^ overflow}, written on the DONE entry edge, and carry/overflow are forced to 0.
- Flags for AND/OR: carry = 0, overflow = 0.
- zero = (ULAsaida == 0), registered on the DONE entry edge.
- in_valid outside IDLE is ignored. No queueing.

## Timing
- Reset values: in_ready=1, out_valid=0, ULAsaida=0, zero=0, carry=0, overflow=0. State IDLE, counter 0.
- Latency:
  - Input handshake at edge T.
  - Bits are processed on edges T+1 … T+WIDTH.
  - out_valid is high from edge T+WIDTH until the output handshake.
- Output handshake at edge U: out_valid=0 and in_ready=1 after U. The next input handshake can occur at the earliest at U+1. Maximum throughput is one operation per WIDTH+1 cycles.
- Back-to-back: with out_ready tied high, DONE lasts exactly one cycle.
- Backpressure: while out_ready=0, all outputs hold indefinitely.
- Counter wrap: the counter is cleared on RUN entry and never exceeds WIDTH-1.
- Reset mid-operation, rst low in any state, takes effect immediately regardless of clk:
  - Return to reset values.
  - The partial result is discarded.
  - The first handshake is possible on the first edge after rst returns high.

## Structure
- Package ula_pkg contains:
  - ula_op_t enum: OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111.
  - ula_state_t enum: IDLE, RUN, DONE.
- Sub-module ula_bit is combinational: inputs a, b, cin, op; outputs s, cout. It covers AND/OR/sum, and cout is valid for the arithmetic ops. One instance is used.
- The top level holds:
  - the FSM
  - the counter, $clog2(WIDTH) bits
  - operand and result shift registers
  - the carry register
  - flag registers

## Test plan
All scenarios use WIDTH=32 with out_ready=1 unless stated.
- ADD a=0x7FFFFFFF, b=0x00000001 → ULAsaida=0x80000000, overflow=1, carry=0, zero=0. out_valid rises exactly 32 edges after the input handshake.
- SUB a=5, b=5 → ULAsaida=0, zero=1, carry=1, overflow=0. SUB a=0, b=1 → 0xFFFFFFFF, carry=0.
- SLT cases:
  - a=0xFFFFFFFF, b=1 → ULAsaida=1.
  - a=0x80000000, b=0x7FFFFFFF, the overflow case → ULAsaida=1.
  - a=1, b=0xFFFFFFFF → ULAsaida=0, zero=1.
- AND and OR with a=0xF0F0F0F0, b=0x0FF00FF0 → AND 0x00F000F0, OR 0xFFF0FFF0, carry=0, overflow=0. Reserved opcode 3'b100 → 0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands applied. Required: outputs unchanged, in_ready=0, new operands not captured. Then out_ready=1 → in_ready=1 on the next cycle.
- Reset mid-run: assert rst=0 asynchronously during bit 10 of an ADD. Required: all outputs at reset values immediately and in_ready=1. After release, a new ADD 2+3 → 5 with normal latency.
